// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Holds the FSM state enum, the requester-id type and memory geometry constants.
// No logic; imported by the interface users, the arbiter top and rr_arb2.
package dmem_arb_pkg;

  // Two-state access sequencer: IDLE arbitrates/accepts, ACCESS drives memory.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Requester identifier: 0 = pipeline MEM stage, 1 = loader/debug port.
  typedef logic port_id_t;

  localparam int unsigned DMEM_WORD_BYTES    = 8;
  localparam int unsigned DMEM_BYTES_DEFAULT = 512;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the request/response handshakes of both requesters and the memory port.
// slave  : arbiter side (consumes requests and read data, drives everything else).
// master : environment side (requesters plus the data memory itself).
// DMEM_ARB_RANGE_CHECK_EN adds the rsp_err_0/rsp_err_1 error strobes.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req_valid_0, req_valid_1;
  logic              req_ready_0, req_ready_1;
  logic              req_write_0, req_write_1;
  logic [ADDR_W-1:0] req_addr_0,  req_addr_1;
  logic [DATA_W-1:0] req_wdata_0, req_wdata_1;
  logic              rsp_valid_0, rsp_valid_1;
  logic [DATA_W-1:0] rsp_rdata_0, rsp_rdata_1;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic              rsp_err_0,   rsp_err_1;
`endif
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  modport slave (
`ifdef DMEM_ARB_RANGE_CHECK_EN
    output rsp_err_0, rsp_err_1,
`endif
    input  req_valid_0, req_valid_1, req_write_0, req_write_1,
    input  req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
    output mem_address, mem_data_in, mem_read, mem_write, busy,
    input  mem_data_out
  );

  modport master (
`ifdef DMEM_ARB_RANGE_CHECK_EN
    input  rsp_err_0, rsp_err_1,
`endif
    output req_valid_0, req_valid_1, req_write_0, req_write_1,
    output req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
    input  mem_address, mem_data_in, mem_read, mem_write, busy,
    output mem_data_out
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a last-grant register.
// Ports: clk, rst (async, active-high), req_i[1:0], accept_i (grant taken), gnt_o[1:0].
// Grant is combinational; last_grant only advances when the grant is actually taken.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  port_id_t last_grant_q;
  port_id_t last_grant_d;

  // On a tie, favour the port that was not served last.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_i) last_grant_d = gnt_o[1];
  end

  // Reset value 1 lets port 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single 64-bit data-memory port between two requesters.
// Ports: clk, rst (async, active-high), bus (dmem_arbiter_if.slave: both request/response
// channels, memory control/data, busy). Accept N, ACCESS N+1, rsp_valid N+2.
// Never accepts while in ACCESS. DMEM_ARB_RANGE_CHECK_EN enables alignment/range errors.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64
`ifdef DMEM_ARB_RANGE_CHECK_EN
  ,
  parameter int MEM_BYTES = DMEM_BYTES_DEFAULT
`endif
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              write_q;
  logic              err_q;
  port_id_t          port_q;
  logic [1:0]        rsp_valid_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              busy_q;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic [1:0]        rsp_err_q;
`endif

  logic [1:0]        req_vld;
  logic [1:0]        gnt;
  logic              idle;
  logic              accept;
  port_id_t          win_id;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  assign req_vld = {bus.req_valid_1, bus.req_valid_0};
  // Gated by rst so ready is low for the whole reset pulse.
  assign idle    = (state_q == IDLE) && !rst;
  assign accept  = idle && (|req_vld);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_vld),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  assign win_id          = gnt[1];
  assign bus.req_ready_0 = idle && gnt[0];
  assign bus.req_ready_1 = idle && gnt[1];

  assign sel_write = win_id ? bus.req_write_1 : bus.req_write_0;
  assign sel_addr  = win_id ? bus.req_addr_1  : bus.req_addr_0;
  assign sel_wdata = win_id ? bus.req_wdata_1 : bus.req_wdata_0;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  // One extra bit so addr+7 cannot wrap past zero near the top of the address space.
  logic [ADDR_W:0] last_byte;
  assign last_byte = {1'b0, sel_addr} + (ADDR_W+1)'(DMEM_WORD_BYTES - 1);
  assign sel_err   = (sel_addr[2:0] != 3'd0) || (last_byte >= (ADDR_W+1)'(MEM_BYTES));
`else
  assign sel_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      port_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
      rsp_err_q   <= 2'b00;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 2'b00;
`ifdef DMEM_ARB_RANGE_CHECK_EN
          rsp_err_q   <= 2'b00;
`endif
          if (accept) begin
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            write_q     <= sel_write;
            err_q       <= sel_err;
            port_q      <= win_id;
            // Memory strobes are registered so they line up exactly with ACCESS;
            // an erroneous request gets an ACCESS cycle with no memory side effect.
            mem_read_q  <= !sel_write && !sel_err;
            mem_write_q <= sel_write && !sel_err;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (err_q)         rdata_q <= '0;
          else if (!write_q) rdata_q <= bus.mem_data_out;
          rsp_valid_q <= port_q ? 2'b10 : 2'b01;
`ifdef DMEM_ARB_RANGE_CHECK_EN
          rsp_err_q   <= err_q ? (port_q ? 2'b10 : 2'b01) : 2'b00;
`endif
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address/data hold their last captured values outside ACCESS.
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.busy        = busy_q;
  assign bus.rsp_valid_0 = rsp_valid_q[0];
  assign bus.rsp_valid_1 = rsp_valid_q[1];
  assign bus.rsp_rdata_0 = rdata_q;
  assign bus.rsp_rdata_1 = rdata_q;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign bus.rsp_err_0   = rsp_err_q[0];
  assign bus.rsp_err_1   = rsp_err_q[1];
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the byte-addressed 64-bit data memory. It shares the single memory port between requester 0 (pipeline MEM stage) and requester 1 (loader/debug port). It registers each request, drives one memory access cycle and returns registered read data with a one-cycle response strobe. It sits between the requesters and the data memory, and owns every memory control signal.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width (8 bytes per access)
- MEM_BYTES, 512, memory size in bytes
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid_0 / req_valid_1  in  1  request present
- req_ready_0 / req_ready_1  out  1  request accepted this cycle
- req_write_0 / req_write_1  in  1  1 = store, 0 = load
- req_addr_0 / req_addr_1  in  ADDR_W  byte address
- req_wdata_0 / req_wdata_1  in  DATA_W  store data
- rsp_valid_0 / rsp_valid_1  out  1  one-cycle completion strobe (loads and stores)
- rsp_rdata_0 / rsp_rdata_1  out  DATA_W  load data; valid only with rsp_valid
- mem_address  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_data_out  in  DATA_W  memory read data (combinational)
- busy  out  1  high whenever state is ACCESS

## Operation
- FSM states: IDLE, ACCESS.
- IDLE:
  - Round-robin arbiter picks a winner among asserted req_valid.
  - req_ready of the winner only is asserted combinationally.
  - On acceptance, capture addr/wdata/write/port-id into registers and go to ACCESS.
- Tie-break: if both valid, grant the port not granted last. last_grant resets to 1, so port 0 wins the first tie.
- Single requester: granted regardless of last_grant.
- ACCESS:
  - mem_address and mem_data_in are driven from the captured registers.
  - mem_read = !write, mem_write = write.
  - At the closing edge: memory commits stores; for loads, mem_data_out is captured into the rdata register.
  - The FSM then returns to IDLE.
- Response: rsp_valid for the captured port-id is registered high for exactly the cycle after ACCESS. rsp_rdata of both ports is driven from the shared rdata register; the value for stores is don't-care.
- mem_read and mem_write are 0 outside ACCESS. mem_address and mem_data_in hold their last values.

## Timing
- Reset values: state = IDLE, last_grant = 1, both rsp_valid = 0, rdata = 0, mem_read = mem_write = 0, busy = 0, both req_ready = 0 while rst is high.
- Latency: accept at cycle N, ACCESS at N+1, rsp_valid at N+2.
- A new request may be accepted in the same cycle as rsp_valid.
- Peak throughput: one access per 2 cycles.
- Handshake: a request transfers when req_valid && req_ready. Requesters hold their request fields stable until ready. The arbiter never accepts while in ACCESS.
- Reset mid-ACCESS: the FSM returns to IDLE asynchronously, so mem_write drops before the next edge. The aborted store is not committed and no response is issued.
- Back-to-back requests from both ports alternate 0,1,0,1.

## Configuration
- DMEM_ARB_RANGE_CHECK_EN defined:
  - At acceptance, flag error if req_addr[2:0] != 0 or req_addr + 7 >= MEM_BYTES.
  - On error, ACCESS keeps mem_read = mem_write = 0 (no memory side effect) and rdata is forced to 0.
  - Adds outputs rsp_err_0 / rsp_err_1, valid with rsp_valid and reset to 0.
- Undefined: no check is made, no rsp_err ports exist, and every access reaches memory.

## Structure
- Package dmem_arb_pkg holds the state enum (IDLE, ACCESS), the port-id type (1 bit) and the constants DMEM_WORD_BYTES = 8 and DMEM_BYTES_DEFAULT = 512.
- Sub-module rr_arb2 contains the 2-way round-robin grant logic and the last_grant register, with grant-accept feedback.

## Test plan
- Reset, then port 0 stores 0x1122334455667788 to address 0x10 and later loads 0x10. Expect mem_write high for exactly one cycle, rsp_valid_0 two cycles after each accept, and load data 0x1122334455667788.
- Both ports valid continuously, each doing loads, for 8 accepts. Expect grant order 0,1,0,1,0,1,0,1, one rsp_valid per accept, and no rsp_valid on the wrong port.
- Assert rst during the ACCESS of a store of 0xDEADBEEF to 0x20. Expect mem_write to fall immediately, no rsp_valid, and a later load of 0x20 to return the prior contents.
- Port 1 only, back-to-back loads of 0x00 and 0x08. Expect accepts 2 cycles apart and the second accept coincident with the first rsp_valid_1.
- With DMEM_ARB_RANGE_CHECK_EN, load from 0x1FC and store to 0x03. Expect rsp_err = 1 for both, rdata = 0, and mem_read/mem_write never high. Then a load from 0x1F8 gives rsp_err = 0.
